// File: rtl/serial_grid_link_pkg.sv
// serial_grid_link_pkg: shared state encoding and sizing helper for the serial grid link
package serial_grid_link_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DUMP,
        DRAIN,
        PRESENT
`ifdef SERIAL_GRID_LINK_VERIFY_EN
        , VERIFY
`endif
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/serial_grid_link_shifter.sv
// serial_grid_link_shifter: MSB-first parallel-to-serial and serial-to-parallel shift pair
module serial_grid_link_shifter #(
    parameter int W = 64
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_shift,
    input  logic         i_cap,
    input  logic         i_cap_bit,
    output logic         o_tx_bit,
    output logic [W-1:0] o_rx_word
);
    logic [W-1:0] r_tx;
    logic [W-1:0] r_rx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx <= '0;
            r_rx <= '0;
        end else begin
            if (i_load)
                r_tx <= i_load_data;
            else if (i_shift)
                r_tx <= {r_tx[W-2:0], 1'b0};
            if (i_cap)
                r_rx <= {r_rx[W-2:0], i_cap_bit};
        end
    end

    assign o_tx_bit  = r_tx[W-1];
    assign o_rx_word = r_rx;
endmodule

// File: rtl/serial_grid_link.sv
// serial_grid_link: host-side load/readout master for the memory shift chain; SERIAL_GRID_LINK_VERIFY_EN adds a post-load readback compare
module serial_grid_link
    import serial_grid_link_pkg::*;
#(
    parameter int data_size = 64
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [data_size-1:0] WR_DATA,
    input  logic                 WR_VALID,
    output logic                 WR_READY,
    input  logic                 RD_REQ,
    output logic [data_size-1:0] RD_DATA,
    output logic                 RD_VALID,
    input  logic                 RD_READY,
    input  logic                 RUN_ACTIVE,
    output logic                 LOAD_MODE,
    output logic                 OUTPUT_MODE,
    output logic                 SER_TX,
    input  logic                 SER_RX,
    output logic                 BUSY,
    output logic                 ABORT
`ifdef SERIAL_GRID_LINK_VERIFY_EN
    ,
    output logic                 LOAD_ERR,
    output logic                 LOAD_ERR_STICKY
`endif
);
    localparam int CW = cnt_width(data_size);
    localparam logic [CW-1:0] LAST = CW'(data_size - 1);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_load_mode;
    logic           r_output_mode;
    logic           r_rd_valid;
    logic           r_abort;
    logic           w_wr_acc;
    logic           w_rd_acc;
    logic           w_cap;
    logic           w_tx_bit;
    logic [data_size-1:0] w_rx_word;
`ifdef SERIAL_GRID_LINK_VERIFY_EN
    logic [data_size-1:0] r_wr_word;
    logic           r_verify;
    logic           r_load_err;
    logic           r_load_err_sticky;
`endif

    assign WR_READY = (r_state == IDLE) & ~RUN_ACTIVE & ~RESET;
    assign w_wr_acc = WR_VALID & WR_READY;
    assign w_rd_acc = RD_REQ & WR_READY & ~WR_VALID;
    // SERIAL_OUT is registered in the memory, so the first DUMP cycle carries no data yet
    assign w_cap    = (r_state == DUMP && r_cnt != '0) || r_state == DRAIN;

    serial_grid_link_shifter #(.W(data_size)) u_shifter (
        .i_clk      (CLK),
        .i_reset    (RESET),
        .i_load     (w_wr_acc),
        .i_load_data(WR_DATA),
        .i_shift    (r_state == LOAD),
        .i_cap      (w_cap),
        .i_cap_bit  (SER_RX),
        .o_tx_bit   (w_tx_bit),
        .o_rx_word  (w_rx_word)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_load_mode   <= 1'b0;
            r_output_mode <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_abort       <= 1'b0;
`ifdef SERIAL_GRID_LINK_VERIFY_EN
            r_wr_word         <= '0;
            r_verify          <= 1'b0;
            r_load_err        <= 1'b0;
            r_load_err_sticky <= 1'b0;
`endif
        end else begin
            r_abort <= 1'b0;
`ifdef SERIAL_GRID_LINK_VERIFY_EN
            r_load_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_wr_acc) begin
                        r_state     <= LOAD;
                        r_cnt       <= '0;
                        r_load_mode <= 1'b1;
`ifdef SERIAL_GRID_LINK_VERIFY_EN
                        r_wr_word   <= WR_DATA;
`endif
                    end else if (w_rd_acc) begin
                        r_state       <= DUMP;
                        r_cnt         <= '0;
                        r_output_mode <= 1'b1;
`ifdef SERIAL_GRID_LINK_VERIFY_EN
                        r_verify      <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (RUN_ACTIVE) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_load_mode <= 1'b0;
                        r_abort     <= 1'b1;
                    end else if (r_cnt == LAST) begin
                        r_cnt       <= '0;
                        r_load_mode <= 1'b0;
`ifdef SERIAL_GRID_LINK_VERIFY_EN
                        r_state       <= DUMP;
                        r_output_mode <= 1'b1;
                        r_verify      <= 1'b1;
`else
                        r_state     <= IDLE;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DUMP: begin
                    if (RUN_ACTIVE) begin
                        r_state       <= IDLE;
                        r_cnt         <= '0;
                        r_output_mode <= 1'b0;
                        r_abort       <= 1'b1;
                    end else if (r_cnt == LAST) begin
                        r_state       <= DRAIN;
                        r_cnt         <= '0;
                        r_output_mode <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (RUN_ACTIVE) begin
                        r_state <= IDLE;
                        r_abort <= 1'b1;
`ifdef SERIAL_GRID_LINK_VERIFY_EN
                    end else if (r_verify) begin
                        r_state <= VERIFY;
`endif
                    end else begin
                        r_state    <= PRESENT;
                        r_rd_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (RD_READY) begin
                        r_state    <= IDLE;
                        r_rd_valid <= 1'b0;
                    end
                end
`ifdef SERIAL_GRID_LINK_VERIFY_EN
                VERIFY: begin
                    r_state           <= IDLE;
                    r_verify          <= 1'b0;
                    r_load_err        <= (w_rx_word != r_wr_word);
                    r_load_err_sticky <= r_load_err_sticky | (w_rx_word != r_wr_word);
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign LOAD_MODE   = r_load_mode;
    assign OUTPUT_MODE = r_output_mode;
    assign SER_TX      = w_tx_bit;
    assign RD_DATA     = w_rx_word;
    assign RD_VALID    = r_rd_valid;
    assign BUSY        = (r_state != IDLE);
    assign ABORT       = r_abort;
`ifdef SERIAL_GRID_LINK_VERIFY_EN
    assign LOAD_ERR        = r_load_err;
    assign LOAD_ERR_STICKY = r_load_err_sticky;
`endif
endmodule

// File: tb/tb_serial_grid_link.sv
// tb_serial_grid_link: randomized self-checking bench with an attached shift-chain memory model
module tb_serial_grid_link;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] wr_data = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic         rd_req = 1'b0;
    logic [N-1:0] rd_data;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic         run_active = 1'b0;
    logic         load_mode;
    logic         output_mode;
    logic         ser_tx;
    logic         ser_rx = 1'b0;
    logic         busy;
    logic         abort_o;
`ifdef SERIAL_GRID_LINK_VERIFY_EN
    logic         load_err;
    logic         load_err_sticky;
`endif

    logic [N-1:0] mem = '0;
    logic [N-1:0] fault_mask = '0;
    logic [N-1:0] ref_mem = '0;
    logic         overlap = 1'b0;
    int           n_chk = 0;
    int           n_pass = 0;

    serial_grid_link #(.data_size(N)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .WR_DATA    (wr_data),
        .WR_VALID   (wr_valid),
        .WR_READY   (wr_ready),
        .RD_REQ     (rd_req),
        .RD_DATA    (rd_data),
        .RD_VALID   (rd_valid),
        .RD_READY   (rd_ready),
        .RUN_ACTIVE (run_active),
        .LOAD_MODE  (load_mode),
        .OUTPUT_MODE(output_mode),
        .SER_TX     (ser_tx),
        .SER_RX     (ser_rx),
        .BUSY       (busy),
        .ABORT      (abort_o)
`ifdef SERIAL_GRID_LINK_VERIFY_EN
        ,
        .LOAD_ERR       (load_err),
        .LOAD_ERR_STICKY(load_err_sticky)
`endif
    );

    always #5 clk = ~clk;

    // Memory shift chain: shifts in on LOAD_MODE, rotates with registered SERIAL_OUT on OUTPUT_MODE
    always @(posedge clk) begin
        if (load_mode)
            mem <= {mem[N-2:0], ser_tx} & ~fault_mask;
        else if (output_mode) begin
            ser_rx <= mem[N-1];
            mem    <= {mem[N-2:0], mem[N-1]} & ~fault_mask;
        end
    end

    always @(negedge clk)
        if (load_mode && output_mode) overlap = 1'b1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        n_chk++;
        if ({load_mode, output_mode, ser_tx, busy, abort_o, rd_valid, wr_ready} !== 7'b0)
            $display("FAIL reset_outputs: got %b want 0000000", {load_mode, output_mode, ser_tx, busy, abort_o, rd_valid, wr_ready});
        else n_pass++;
        n_chk++;
        if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 00", rd_data);
        else n_pass++;
        rst = 1'b0;
        tick;
        n_chk++;
        if (wr_ready !== 1'b1 || busy !== 1'b0) $display("FAIL post_reset_ready: got rdy=%b busy=%b want 1 0", wr_ready, busy);
        else n_pass++;
        wr_data = N'($urandom);
        wr_valid = 1'b1;
        tick;
        wr_valid = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({load_mode, busy, abort_o} !== 3'b0) $display("FAIL mid_reset: got load=%b busy=%b abort=%b want 000", load_mode, busy, abort_o);
        else n_pass++;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_write(input logic [N-1:0] d);
        int n;
        logic [N-1:0] bits;
        n_chk++;
        if (wr_ready !== 1'b1) $display("FAIL write_ready: got %b want 1", wr_ready);
        else n_pass++;
        wr_data = d;
        wr_valid = 1'b1;
        tick;
        wr_valid = 1'b0;
        n = 0;
        bits = '0;
        while (load_mode === 1'b1 && n < 3 * N) begin
            bits = {bits[N-2:0], ser_tx};
            n++;
            tick;
        end
        n_chk++;
        if (n != N) $display("FAIL load_len: got %0d want %0d", n, N);
        else n_pass++;
        n_chk++;
        if (bits !== d) $display("FAIL ser_tx_seq: got %h want %h", bits, d);
        else n_pass++;
        n_chk++;
        if (mem !== d) $display("FAIL mem_after_write: got %h want %h", mem, d);
        else n_pass++;
        ref_mem = d;
    endtask

    task automatic test_read(input int hold, input logic run_in_present);
        int lat;
        int om;
        logic [N-1:0] held;
        rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        lat = 1;
        om = 0;
        while (rd_valid !== 1'b1 && lat < 4 * N) begin
            om += int'(output_mode);
            tick;
            lat++;
        end
        n_chk++;
        if (lat != N + 2) $display("FAIL read_latency: got %0d want %0d", lat, N + 2);
        else n_pass++;
        n_chk++;
        if (om != N) $display("FAIL output_mode_len: got %0d want %0d", om, N);
        else n_pass++;
        n_chk++;
        if (rd_data !== ref_mem) $display("FAIL rd_data: got %h want %h", rd_data, ref_mem);
        else n_pass++;
        n_chk++;
        if (mem !== ref_mem) $display("FAIL mem_after_read: got %h want %h", mem, ref_mem);
        else n_pass++;
        held = rd_data;
        run_active = run_in_present;
        for (int i = 0; i < hold; i++) begin
            tick;
            n_chk++;
            if (rd_valid !== 1'b1 || rd_data !== held || wr_ready !== 1'b0)
                $display("FAIL present_hold: got vld=%b data=%h rdy=%b want 1 %h 0", rd_valid, rd_data, wr_ready, held);
            else n_pass++;
        end
        run_active = 1'b0;
        rd_ready = 1'b1;
        tick;
        rd_ready = 1'b0;
        n_chk++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL read_done: got vld=%b busy=%b rdy=%b want 0 0 1", rd_valid, busy, wr_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        test_read(0, 1'b0);
        test_read(0, 1'b0);
    endtask

    task automatic test_priority;
        int n;
        wr_data = 8'h3C;
        wr_valid = 1'b1;
        rd_req = 1'b1;
        tick;
        wr_valid = 1'b0;
        n_chk++;
        if (load_mode !== 1'b1 || output_mode !== 1'b0) $display("FAIL prio_write_first: got load=%b out=%b want 1 0", load_mode, output_mode);
        else n_pass++;
        n = 0;
        while (output_mode !== 1'b1 && n < 3 * N) begin
            tick;
            n++;
        end
        rd_req = 1'b0;
        ref_mem = 8'h3C;
        n = 0;
        while (rd_valid !== 1'b1 && n < 4 * N) begin
            tick;
            n++;
        end
        n_chk++;
        if (rd_valid !== 1'b1 || rd_data !== ref_mem) $display("FAIL prio_readback: got vld=%b data=%h want 1 %h", rd_valid, rd_data, ref_mem);
        else n_pass++;
        rd_ready = 1'b1;
        tick;
        rd_ready = 1'b0;
    endtask

    task automatic test_abort;
        logic seen;
        run_active = 1'b1;
        #1;
        n_chk++;
        if (wr_ready !== 1'b0) $display("FAIL run_blocks_ready: got %b want 0", wr_ready);
        else n_pass++;
        run_active = 1'b0;
        #1;
        wr_data = N'($urandom);
        wr_valid = 1'b1;
        tick;
        wr_valid = 1'b0;
        repeat (3) tick;
        run_active = 1'b1;
        tick;
        run_active = 1'b0;
        n_chk++;
        if ({load_mode, abort_o, busy, rd_valid} !== 4'b0100)
            $display("FAIL abort_load: got load=%b abort=%b busy=%b vld=%b want 0 1 0 0", load_mode, abort_o, busy, rd_valid);
        else n_pass++;
        tick;
        n_chk++;
        if (abort_o !== 1'b0) $display("FAIL abort_pulse_width: got %b want 0", abort_o);
        else n_pass++;
        rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
        repeat (4) tick;
        run_active = 1'b1;
        tick;
        run_active = 1'b0;
        n_chk++;
        if ({output_mode, abort_o, busy} !== 3'b010)
            $display("FAIL abort_dump: got out=%b abort=%b busy=%b want 0 1 0", output_mode, abort_o, busy);
        else n_pass++;
        seen = 1'b0;
        repeat (2 * N) begin
            seen |= rd_valid;
            tick;
        end
        n_chk++;
        if (seen !== 1'b0) $display("FAIL abort_no_rd_valid: got %b want 0", seen);
        else n_pass++;
    endtask

    task automatic test_random;
        repeat (4) begin
            test_write(N'($urandom));
            test_read($urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_invariant;
        n_chk++;
        if (overlap !== 1'b0) $display("FAIL mode_overlap: got %b want 0", overlap);
        else n_pass++;
    endtask

`ifdef SERIAL_GRID_LINK_VERIFY_EN
    task automatic test_verify(input logic [N-1:0] d, input logic [N-1:0] fm, input int exp_pulses);
        int pulses;
        logic seen;
        fault_mask = fm;
        wr_data = d;
        wr_valid = 1'b1;
        tick;
        wr_valid = 1'b0;
        pulses = 0;
        seen = 1'b0;
        repeat (4 * N) begin
            pulses += int'(load_err);
            seen |= rd_valid;
            tick;
        end
        fault_mask = '0;
        n_chk++;
        if (pulses != exp_pulses) $display("FAIL load_err_pulses: got %0d want %0d", pulses, exp_pulses);
        else n_pass++;
        n_chk++;
        if (load_err_sticky !== 1'b1) $display("FAIL load_err_sticky: got %b want 1", load_err_sticky);
        else n_pass++;
        n_chk++;
        if (seen !== 1'b0 || wr_ready !== 1'b1) $display("FAIL verify_quiet: got vld=%b rdy=%b want 0 1", seen, wr_ready);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset;
`ifdef SERIAL_GRID_LINK_VERIFY_EN
        test_verify(8'hF0, 8'h80, 1);
        test_verify(8'h5A, 8'h00, 0);
`else
        test_write(8'hA5);
        test_back_to_back;
        test_priority;
        test_abort;
        test_write(N'($urandom));
        test_read(5, 1'b1);
        test_random;
`endif
        test_invariant;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
